// File: rtl/cnn_dram_pkg.sv
// Shared types and constants for the CNN output-to-DRAM path.
// Command encoding, row/column split and output region base.
package cnn_dram_pkg;

  typedef enum logic [1:0] {
    NOP,
    ACT,
    WRITE,
    PRE
  } dram_cmd_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACT,
    S_RCD,
    S_WRITE,
    S_PRE,
    S_RP,
    S_DONE
  } wb_state_e;

  localparam int ROW_LSB = 10;
  localparam int COL_W   = 10;

  localparam logic [22:0] OUTPUT_START = 23'h180000;

endpackage

// File: rtl/wb_fifo.sv
// Small synchronous FIFO buffering words ahead of DRAM writes.
// Simultaneous push and pop are both honoured; no write-through.
module wb_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wp;
  logic [AW-1:0]    rp;
  logic [AW:0]      cnt;
  logic             do_push;
  logic             do_pop;

  assign full    = (cnt == (AW+1)'(DEPTH));
  assign empty   = (cnt == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rp];

  // Pointer and occupancy tracking
  always_ff @(posedge clk) begin
    if (rst) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop)  rp <= rp + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage array, written on accepted pushes
  always_ff @(posedge clk) begin
    if (do_push) mem[wp] <= wdata;
  end

endmodule

// File: rtl/dram_writeback.sv
// Streams output-SRAM words into a contiguous DRAM region.
// Optional DRAM_WB_RELU_EN zeroes negative words at writeback.
module dram_writeback
  import cnn_dram_pkg::*;
#(
  parameter int ADDR_W     = 23,
  parameter int WC_W       = 22,
  parameter int FIFO_DEPTH = 4,
  parameter int T_RCD      = 2,
  parameter int T_RP       = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [WC_W-1:0]   word_count,
  input  logic              src_valid,
  input  logic [31:0]       src_data,
  output logic              src_ready,
  output logic              busy,
  output logic              done,
  output logic              CSn,
  output logic              RASn,
  output logic              CASn,
  output logic [3:0]        WEn,
  output logic [12:0]       A,
  output logic [31:0]       D
);

  wb_state_e         state;
  wb_state_e         state_nxt;
  dram_cmd_e         cmd;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W-1:0] addr_inc;
  logic [WC_W-1:0]   wc;
  logic [WC_W-1:0]   remaining;
  logic [WC_W-1:0]   pushed;
  logic [3:0]        wait_cnt;
  logic [3:0]        wait_val;
  logic              wait_load;
  logic              push;
  logic              pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [31:0]       fifo_q;
  logic [31:0]       wdata;
  logic              accept;

  assign src_ready = busy && !fifo_full && (pushed < wc);
  assign push      = src_valid && src_ready;
  assign addr_inc  = addr + 1'b1;
  assign accept    = (state == S_IDLE) && start;

`ifdef DRAM_WB_RELU_EN
  assign wdata = fifo_q[31] ? 32'h0 : fifo_q;
`else
  assign wdata = fifo_q;
`endif

  wb_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata (src_data),
    .rdata (fifo_q),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next state, command to register and FIFO pop
  always_comb begin
    state_nxt = state;
    cmd       = NOP;
    pop       = 1'b0;
    wait_load = 1'b0;
    wait_val  = '0;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          if (word_count == '0) state_nxt = S_DONE;
          else                  state_nxt = S_ACT;
        end
      end
      S_ACT: begin
        cmd       = ACT;
        state_nxt = S_RCD;
        wait_load = 1'b1;
        wait_val  = 4'(T_RCD - 1);
      end
      S_RCD: begin
        if (wait_cnt <= 4'd1) state_nxt = S_WRITE;
      end
      S_WRITE: begin
        if (!fifo_empty) begin
          cmd = WRITE;
          pop = 1'b1;
          if (remaining == WC_W'(1) ||
              addr_inc[COL_W-1:0] == '0)
            state_nxt = S_PRE;
        end
      end
      S_PRE: begin
        cmd       = PRE;
        state_nxt = S_RP;
        wait_load = 1'b1;
        wait_val  = 4'(T_RP - 1);
      end
      S_RP: begin
        if (wait_cnt <= 4'd1) begin
          if (remaining != '0) state_nxt = S_ACT;
          else                 state_nxt = S_DONE;
        end
      end
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Job bookkeeping: address, counts, wait timer, busy/done
  always_ff @(posedge clk) begin
    if (rst) begin
      addr      <= '0;
      wc        <= '0;
      remaining <= '0;
      pushed    <= '0;
      wait_cnt  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      if (wait_load)
        wait_cnt <= wait_val;
      else if (wait_cnt != '0)
        wait_cnt <= wait_cnt - 1'b1;
      if (accept) begin
        addr      <= base_addr;
        wc        <= word_count;
        remaining <= word_count;
        pushed    <= '0;
        busy      <= 1'b1;
      end
      if (push) pushed <= pushed + 1'b1;
      if (pop) begin
        addr      <= addr_inc;
        remaining <= remaining - 1'b1;
      end
      done <= (state == S_DONE);
      if (state == S_DONE) busy <= 1'b0;
    end
  end

  // Registered DRAM command pins
  always_ff @(posedge clk) begin
    if (rst) begin
      CSn  <= 1'b1;
      RASn <= 1'b1;
      CASn <= 1'b1;
      WEn  <= 4'hF;
      A    <= '0;
      D    <= '0;
    end else begin
      unique case (cmd)
        NOP: begin
          CSn  <= 1'b1;
          RASn <= 1'b1;
          CASn <= 1'b1;
          WEn  <= 4'hF;
        end
        ACT: begin
          CSn  <= 1'b0;
          RASn <= 1'b0;
          CASn <= 1'b1;
          WEn  <= 4'hF;
          A    <= 13'(addr[ADDR_W-1:ROW_LSB]);
        end
        WRITE: begin
          CSn  <= 1'b0;
          RASn <= 1'b1;
          CASn <= 1'b0;
          WEn  <= 4'h0;
          A    <= 13'(addr[COL_W-1:0]);
          D    <= wdata;
        end
        PRE: begin
          CSn  <= 1'b0;
          RASn <= 1'b0;
          CASn <= 1'b1;
          WEn  <= 4'h0;
        end
      endcase
    end
  end

endmodule
